// File: rtl/natural_log_arbiter_if.sv
// Requester-side bus of the shared natural-log arbiter: request strobes and operands in,
// grants, result pulses, results and busy flags out.
interface natural_log_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 16,
    parameter int Y_W     = 16
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*X_W-1:0] req_x;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ*Y_W-1:0] rsp_y;
    logic [NUM_REQ-1:0]     busy;

    modport master (
        output req_valid, req_x,
        input  req_ready, rsp_valid, rsp_y, busy
    );

    modport slave (
        input  req_valid, req_x,
        output req_ready, rsp_valid, rsp_y, busy
    );
endinterface

// File: rtl/natural_log_arbiter.sv
// Round-robin arbiter sharing one pipelined ln(x) core among NUM_REQ requesters.
// Optional per-requester last-result cache is enabled by defining NATURAL_LOG_ARB_CACHE_EN.
module natural_log_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int X_W        = 16,
    parameter int Y_W        = 16,
    parameter int LN_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    natural_log_arbiter_if.slave req_bus,
    output logic                 ln_valid,
    output logic [X_W-1:0]       ln_x,
    input  logic [Y_W-1:0]       ln_y
);
    localparam int              ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              STAGES  = LN_LATENCY + 1;
    localparam logic [Y_W-1:0]  SAT_Y   = {1'b1, {(Y_W-1){1'b0}}};
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, PENDING} req_state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            zero;
    } tag_t;

    req_state_t             state     [NUM_REQ];
    logic [Y_W-1:0]         rsp_y_reg [NUM_REQ];
    tag_t                   tag_pipe  [STAGES];
    tag_t                   ret;
    logic [NUM_REQ-1:0]     rsp_valid_reg;
    logic [NUM_REQ-1:0]     busy_vec;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [NUM_REQ*Y_W-1:0] rsp_y_flat;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_valid;
    logic                   grant_zero;
    logic                   grant_hit;
    logic                   issue;
    logic [X_W-1:0]         grant_x;
    logic [Y_W-1:0]         hit_y;
    int                     idx;

    always_comb begin
        busy_vec   = '0;
        eligible   = '0;
        rsp_y_flat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy_vec[i] = (state[i] == PENDING);
            eligible[i] = req_bus.req_valid[i] && (state[i] == IDLE);
            rsp_y_flat[i*Y_W +: Y_W] = rsp_y_reg[i];
        end
    end

    // Search from rr_ptr upward, wrapping; the first eligible requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_id] = 1'b1;
        end
    end

    assign grant_x    = req_bus.req_x[grant_id*X_W +: X_W];
    assign grant_zero = (grant_x == '0);
    assign issue      = grant_valid && !grant_hit;
    assign ret        = tag_pipe[STAGES-1];

    assign req_bus.req_ready = grant_onehot;
    assign req_bus.rsp_valid = rsp_valid_reg;
    assign req_bus.rsp_y     = rsp_y_flat;
    assign req_bus.busy      = busy_vec;

`ifdef NATURAL_LOG_ARB_CACHE_EN
    logic [NUM_REQ-1:0] cache_valid;
    logic [X_W-1:0]     last_x [NUM_REQ];
    logic [Y_W-1:0]     last_y [NUM_REQ];
    logic [X_W-1:0]     pend_x [NUM_REQ];

    assign grant_hit = grant_valid && cache_valid[grant_id] && (last_x[grant_id] == grant_x);
    assign hit_y     = last_y[grant_id];

    // Operand is parked per requester so the return can refresh the cache entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                last_x[i] <= '0;
                last_y[i] <= '0;
                pend_x[i] <= '0;
            end
        end else begin
            if (issue) begin
                pend_x[grant_id] <= grant_x;
            end
            if (ret.valid && !ret.zero) begin
                cache_valid[ret.id] <= 1'b1;
                last_x[ret.id]      <= pend_x[ret.id];
                last_y[ret.id]      <= ln_y;
            end
        end
    end
`else
    assign grant_hit = 1'b0;
    assign hit_y     = '0;
`endif

    // A returning requester is PENDING, so it can never be the one granted this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            ln_valid      <= 1'b0;
            ln_x          <= '0;
            rsp_valid_reg <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                state[i]     <= IDLE;
                rsp_y_reg[i] <= '0;
            end
            for (int s = 0; s < STAGES; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            ln_valid <= issue && !grant_zero;
            if (issue && !grant_zero) begin
                ln_x <= grant_x;
            end

            tag_pipe[0].valid <= issue;
            tag_pipe[0].id    <= grant_id;
            tag_pipe[0].zero  <= grant_zero;
            for (int s = 1; s < STAGES; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end

            rsp_valid_reg <= '0;
            if (ret.valid) begin
                rsp_valid_reg[ret.id] <= 1'b1;
                rsp_y_reg[ret.id]     <= ret.zero ? SAT_Y : ln_y;
                state[ret.id]         <= IDLE;
            end

            if (grant_valid) begin
                rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                if (grant_hit) begin
                    rsp_valid_reg[grant_id] <= 1'b1;
                    rsp_y_reg[grant_id]     <= hit_y;
                end else begin
                    state[grant_id] <= PENDING;
                end
            end
        end
    end
endmodule

// File: tb/tb_natural_log_arbiter.sv
// Self-checking bench for natural_log_arbiter: vector table, corner-case sequences and a
// cycle-level scoreboard with an independent round-robin model. Cache tests need NATURAL_LOG_ARB_CACHE_EN.
module tb_natural_log_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int X_W        = 16;
    localparam int Y_W        = 16;
    localparam int LN_LATENCY = 3;
    localparam int LAT        = LN_LATENCY + 2;

`ifdef NATURAL_LOG_ARB_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [15:0] x;
        logic [15:0] exp_y;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] x;
        logic [15:0] y;
        int          due;
        bit          hit;
    } exp_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        ln_valid;
    logic [15:0] ln_x;
    logic [15:0] ln_y;
    logic [15:0] ln_pipe [LN_LATENCY];

    int cyc          = 0;
    int n_compared   = 0;
    int n_mismatched = 0;

    vec_t vecs [6];
    exp_t sb [$];

    logic [NUM_REQ-1:0] m_busy;
    logic [NUM_REQ-1:0] m_cv;
    logic [NUM_REQ-1:0] exp_rv;
    logic [NUM_REQ-1:0] exp_ready;
    logic [15:0]        m_rsp_y [NUM_REQ];
    logic [15:0]        m_lx    [NUM_REQ];
    logic [15:0]        m_ly    [NUM_REQ];
    logic [15:0]        m_lnx;
    logic [15:0]        gx;
    logic               m_lnv;
    logic               m_lnv_n;
    bit                 m_hit;
    int                 m_rr;
    int                 g;
    exp_t               e;

    natural_log_arbiter_if #(.NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W)) bus ();

    natural_log_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .LN_LATENCY(LN_LATENCY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_bus (bus),
        .ln_valid(ln_valid),
        .ln_x    (ln_x),
        .ln_y    (ln_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ln_fn(input logic [15:0] x);
        return x ^ 16'hA5A5;
    endfunction

    // Stand-in ln core: garbage whenever nothing was issued, so mis-timed sampling shows up.
    always @(posedge clk) begin
        ln_pipe[0] <= ln_valid ? ln_fn(ln_x) : 16'hDEAD;
        for (int k = 1; k < LN_LATENCY; k++) begin
            ln_pipe[k] <= ln_pipe[k-1];
        end
    end
    assign ln_y = ln_pipe[LN_LATENCY-1];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model, evaluated mid-cycle: responses due now, then this cycle's grant.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            m_busy = '0;
            m_cv   = '0;
            m_rr   = 0;
            m_lnv  = 1'b0;
            m_lnx  = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                m_rsp_y[i] = '0;
                m_lx[i]    = '0;
                m_ly[i]    = '0;
            end
        end else begin
            exp_rv = '0;
            for (int q = sb.size() - 1; q >= 0; q--) begin
                if (sb[q].due == cyc) begin
                    exp_rv[sb[q].id]  = 1'b1;
                    m_rsp_y[sb[q].id] = sb[q].y;
                    if (!sb[q].hit && sb[q].x != 16'h0000) begin
                        m_cv[sb[q].id] = 1'b1;
                        m_lx[sb[q].id] = sb[q].x;
                        m_ly[sb[q].id] = sb[q].y;
                    end
                    sb.delete(q);
                end
            end
            check_output("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
            for (int i = 0; i < NUM_REQ; i++) begin
                check_output($sformatf("rsp_y%0d", i), 32'(bus.rsp_y[i*16 +: 16]), 32'(m_rsp_y[i]));
            end
            check_output("busy", 32'(bus.busy), 32'(m_busy));
            check_output("ln_valid", 32'(ln_valid), 32'(m_lnv));
            check_output("ln_x", 32'(ln_x), 32'(m_lnx));

            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && bus.req_valid[(m_rr + k) % NUM_REQ] && !m_busy[(m_rr + k) % NUM_REQ]) begin
                    g = (m_rr + k) % NUM_REQ;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check_output("req_ready", 32'(bus.req_ready), 32'(exp_ready));

            m_lnv_n = 1'b0;
            if (g >= 0) begin
                gx    = bus.req_x[g*16 +: 16];
                m_hit = CACHE_EN && m_cv[g] && (m_lx[g] == gx);
                e.id  = g;
                e.x   = gx;
                e.hit = m_hit;
                if (m_hit) begin
                    e.y   = m_ly[g];
                    e.due = cyc + 1;
                end else begin
                    e.y       = (gx == 16'h0000) ? 16'h8000 : ln_fn(gx);
                    e.due     = cyc + LAT;
                    m_busy[g] = 1'b1;
                    if (gx != 16'h0000) begin
                        m_lnv_n = 1'b1;
                        m_lnx   = gx;
                    end
                end
                sb.push_back(e);
                m_rr = (g + 1) % NUM_REQ;
            end
            foreach (sb[q]) begin
                if (!sb[q].hit && sb[q].due == cyc + 1) m_busy[sb[q].id] = 1'b0;
            end
            m_lnv = m_lnv_n;
        end
    end

    task automatic apply_stimulus(input int id, input logic [15:0] x, input logic [15:0] exp_y,
                                  input int exp_lat, input string name);
        int acc_cyc;
        int rsp_cyc;
        acc_cyc = -1;
        rsp_cyc = -1;
        @(posedge clk); #1;
        bus.req_x[id*16 +: 16] = x;
        bus.req_valid[id]      = 1'b1;
        for (int t = 0; t < 20 && acc_cyc < 0; t++) begin
            @(negedge clk);
            if (bus.req_ready[id]) acc_cyc = cyc;
        end
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        check_output({name, "_accept"}, 32'(acc_cyc >= 0), 32'd1);
        for (int t = 0; t < 20 && rsp_cyc < 0; t++) begin
            @(negedge clk);
            if (bus.rsp_valid[id]) rsp_cyc = cyc;
        end
        check_output({name, "_lat"}, 32'(rsp_cyc - acc_cyc), 32'(exp_lat));
        check_output({name, "_y"}, 32'(bus.rsp_y[id*16 +: 16]), 32'(exp_y));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int                 order [4];
        int                 ng;
        int                 multi;
        int                 stale;
        bit                 seen;
        logic               acc1;
        logic [NUM_REQ-1:0] acc;

        bus.req_valid = '0;
        bus.req_x     = '0;

        vecs[0] = '{0, 16'h0100, 16'hA4A5, LAT};
        vecs[1] = '{1, 16'h1234, 16'hB791, LAT};
        vecs[2] = '{2, 16'h0000, 16'h8000, LAT};
        vecs[3] = '{3, 16'hFFFF, 16'h5A5A, LAT};
        vecs[4] = '{2, 16'h0001, 16'hA5A4, LAT};
        vecs[5] = '{1, 16'h8000, 16'h25A5, LAT};

        #3 reset_n = 1'b0;
        #1;
        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_ln_valid", 32'(ln_valid), 32'd0);
        check_output("reset_ln_x", 32'(ln_x), 32'd0);
        check_output("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check_output("reset_rsp_y_lo", bus.rsp_y[31:0], 32'd0);
        check_output("reset_rsp_y_hi", bus.rsp_y[63:32], 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].id, vecs[v].x, vecs[v].exp_y, vecs[v].exp_lat, $sformatf("vec%0d", v));
            repeat (2) @(posedge clk);
        end

        // All four requesters hammering from reset release.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) bus.req_x[i*16 +: 16] = 16'h1000 + 16'(i * 256);
        bus.req_valid = '1;
        ng    = 0;
        multi = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            acc = bus.req_ready & bus.req_valid;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && ng < 4) begin
                    order[ng] = i;
                    ng++;
                end
            end
            if ($countones(bus.rsp_valid) > 1) multi++;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) bus.req_x[i*16 +: 16] = bus.req_x[i*16 +: 16] + 16'h0001;
            end
        end
        bus.req_valid = '0;
        check_output("grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("grant_order%0d", k), 32'(order[k]), 32'(k));
        end
        check_output("rsp_overlap", 32'(multi), 32'd0);
        repeat (8) @(posedge clk);

        // Reset while three requests are in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) bus.req_x[i*16 +: 16] = 16'h2000 + 16'(i * 16);
        bus.req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = '0;
        #1 reset_n = 1'b0;
        #1;
        check_output("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("midrst_busy", 32'(bus.busy), 32'd0);
        check_output("midrst_ln_valid", 32'(ln_valid), 32'd0);
        check_output("midrst_ln_x", 32'(ln_x), 32'd0);
        check_output("midrst_rsp_y_lo", bus.rsp_y[31:0], 32'd0);
        check_output("midrst_rsp_y_hi", bus.rsp_y[63:32], 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) stale++;
        end
        check_output("stale_rsp", 32'(stale), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) bus.req_x[i*16 +: 16] = 16'h3000 + 16'(i * 16);
        bus.req_valid = '1;
        @(negedge clk);
        check_output("first_grant_after_reset", 32'(bus.req_ready), 32'h1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (8) @(posedge clk);

        // Requester 1 keeps requesting; it must be granted in its own response cycle.
        @(posedge clk); #1;
        bus.req_x[16 +: 16] = 16'h0300;
        bus.req_valid[1]    = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            acc1 = bus.req_ready[1];
            if (bus.rsp_valid[1]) begin
                check_output("rerequest_ready", 32'(bus.req_ready[1]), 32'd1);
                seen = 1'b1;
            end
            @(posedge clk); #1;
            if (acc1) bus.req_x[16 +: 16] = bus.req_x[16 +: 16] + 16'h0011;
        end
        bus.req_valid[1] = 1'b0;
        check_output("rerequest_seen", 32'(seen), 32'd1);
        repeat (8) @(posedge clk);

`ifdef NATURAL_LOG_ARB_CACHE_EN
        apply_stimulus(3, 16'h0400, 16'hA1A5, LAT, "cache_miss");
        apply_stimulus(3, 16'h0400, 16'hA1A5, 1, "cache_hit");
        apply_stimulus(3, 16'h0401, 16'hA1A4, LAT, "cache_new");
        repeat (4) @(posedge clk);
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
